ps_iter: RTL and testbench
==========================

# ps_iter

Iterative, parametrised ASCON substitution layer (pS) with forward and inverse modes. It captures a 320-bit state and applies the 5-bit S-box to its 64 columns, SBOX_PER_CYCLE columns per clock, trading latency for area. It sits beside the combinational substitution stage in the permutation datapath and is driven by the permutation FSM through a start/done handshake. Inverse mode serves decryption-side and self-check use.

## Interface
- SBOX_PER_CYCLE, default 8: S-boxes instantiated, i.e. columns processed per cycle. Legal values: 1, 2, 4, 8, 16, 32, 64. Any other value is an elaboration error.
- clock_i  input  1  rising-edge clock, single clock domain
- reset_i  input  1  synchronous, active-high reset
- start_i  input  1  request; sampled only in IDLE
- inv_i  input  1  0 = forward S-box, 1 = inverse S-box; sampled together with start_i
- state_i  input  type_state (5×64 = 320 bits)  state to substitute; sampled together with start_i
- substitution_o  output  type_state  working register; final result once done_o has pulsed
- busy_o  output  1  high while in RUN
- done_o  output  1  one-cycle pulse: result complete

## Operation
- N = 64 / SBOX_PER_CYCLE iterations. Column j = {x0[j],x1[j],x2[j],x3[j],x4[j]}, with x0 as the MSB.
- Forward S-box, input 0..31: 04 0b 1f 14 1a 15 09 02 1b 05 08 12 1d 03 06 1c 1e 13 07 0e 00 0d 11 18 10 0c 01 19 16 0a 0f 17.
- Inverse S-box, input 0..31: 14 1a 07 0d 00 09 0e 12 0a 06 1d 01 19 15 13 1e 18 16 0b 11 03 05 1c 1f 17 1b 04 08 0f 0c 10 02.
- FSM with two states:
  - IDLE: start_i=1 loads state_i into the working register, latches inv_i into mode_q, clears the column counter cnt, and moves to RUN.
  - RUN: each cycle replaces columns [cnt·SBOX_PER_CYCLE, (cnt+1)·SBOX_PER_CYCLE−1] in place with S(col) or S⁻¹(col) according to mode_q, then increments cnt. On the edge that processes cnt = N−1, the FSM returns to IDLE and sets done_o.
- cnt width is $clog2(N), minimum 1 bit. cnt never exceeds N−1; there is no wrap inside a run.
- Changes to start_i, inv_i or state_i while busy_o=1 are ignored.
- In IDLE, substitution_o holds its last value until the next accepted start.
- During RUN, substitution_o shows partially substituted state. It is only valid from the done_o cycle onward.

## Timing
- Reset values: working register all-zero, substitution_o = 0, busy_o = 0, done_o = 0, cnt = 0, mode_q = 0, FSM in IDLE.
- Clock edge E samples start_i=1:
  - busy_o is high from after E through the cycle in which the last update edge E+N occurs.
  - done_o is high for exactly one cycle, after edge E+N. substitution_o is final in that same cycle.
- Latency from start to done is N cycles; SBOX_PER_CYCLE=64 gives 1 cycle.
- Throughput is one state per N cycles. A start_i asserted during the done_o cycle is accepted, because the FSM is already in IDLE; back-to-back operation has no bubble.
- reset_i asserted mid-run: at the next edge the run is aborted and all reset values above apply. No done_o pulse is produced.
- reset_i and start_i asserted together: reset wins.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Zero vector, forward: state_i = all-zero, start -> done_o exactly N cycles later; substitution_o = {x0=0, x1=0, x2=FFFFFFFFFFFFFFFF, x3=0, x4=0}.
- All-ones vector: state_i = all-ones, forward -> {x0=ones, x1=0, x2=ones, x3=ones, x4=ones}. Then feed that result back with inv_i=1 -> all-ones again.
- Specification vector 00001000808c0001_6cb10ad9ca912f80_691aed630e8190ef_0c4c36a20853217c_46487b3e06d9d7a8:
  - forward result equals the output of the combinational ps module on the same input;
  - inverse of that result returns the original vector;
  - run for SBOX_PER_CYCLE = 1, 8 and 64, with done latencies 64, 8 and 1 respectively.
- Busy protection: change state_i and inv_i and pulse start_i mid-run -> result unchanged, single done_o pulse. Then assert start_i during the done_o cycle -> the second run starts immediately and its done_o arrives N cycles later.
- Reset mid-run: reset_i at iteration N/2 -> next cycle busy_o=0, done_o=0, substitution_o=0. No done_o pulse appears afterward without a new start.
- Randomised: 1000 random states in random modes -> each forward result matches the golden model, and each inverse result matches the golden inverse model.

Source files
------------

// File: rtl/ps_iter.sv
// Iterative ASCON substitution layer: applies the 5-bit S-box (or its inverse)
// to SBOX_PER_CYCLE columns of a 320-bit state per clock until all 64 are done.
module ps_iter #(
   parameter int SBOX_PER_CYCLE = 8
) (
   input  logic         clock_i,
   input  logic         reset_i,
   input  logic         start_i,
   input  logic         inv_i,
   input  logic [319:0] state_i,
   output logic [319:0] substitution_o,
   output logic         busy_o,
   output logic         done_o
);

   localparam int N  = 64 / SBOX_PER_CYCLE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   generate
      if (SBOX_PER_CYCLE != 1 && SBOX_PER_CYCLE != 2 && SBOX_PER_CYCLE != 4 &&
          SBOX_PER_CYCLE != 8 && SBOX_PER_CYCLE != 16 && SBOX_PER_CYCLE != 32 &&
          SBOX_PER_CYCLE != 64) begin : g_bad_param
         $error("ps_iter: SBOX_PER_CYCLE must be a power of two between 1 and 64");
      end
   endgenerate

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   function automatic logic [4:0] sbox_fwd(input logic [4:0] x);
      logic [4:0] s;
      s = '0;
      case (x)
         5'd0:  s = 5'h04; 5'd1:  s = 5'h0b; 5'd2:  s = 5'h1f; 5'd3:  s = 5'h14;
         5'd4:  s = 5'h1a; 5'd5:  s = 5'h15; 5'd6:  s = 5'h09; 5'd7:  s = 5'h02;
         5'd8:  s = 5'h1b; 5'd9:  s = 5'h05; 5'd10: s = 5'h08; 5'd11: s = 5'h12;
         5'd12: s = 5'h1d; 5'd13: s = 5'h03; 5'd14: s = 5'h06; 5'd15: s = 5'h1c;
         5'd16: s = 5'h1e; 5'd17: s = 5'h13; 5'd18: s = 5'h07; 5'd19: s = 5'h0e;
         5'd20: s = 5'h00; 5'd21: s = 5'h0d; 5'd22: s = 5'h11; 5'd23: s = 5'h18;
         5'd24: s = 5'h10; 5'd25: s = 5'h0c; 5'd26: s = 5'h01; 5'd27: s = 5'h19;
         5'd28: s = 5'h16; 5'd29: s = 5'h0a; 5'd30: s = 5'h0f; 5'd31: s = 5'h17;
         default: s = '0;
      endcase
      return s;
   endfunction

   function automatic logic [4:0] sbox_inv(input logic [4:0] x);
      logic [4:0] s;
      s = '0;
      case (x)
         5'd0:  s = 5'h14; 5'd1:  s = 5'h1a; 5'd2:  s = 5'h07; 5'd3:  s = 5'h0d;
         5'd4:  s = 5'h00; 5'd5:  s = 5'h09; 5'd6:  s = 5'h0e; 5'd7:  s = 5'h12;
         5'd8:  s = 5'h0a; 5'd9:  s = 5'h06; 5'd10: s = 5'h1d; 5'd11: s = 5'h01;
         5'd12: s = 5'h19; 5'd13: s = 5'h15; 5'd14: s = 5'h13; 5'd15: s = 5'h1e;
         5'd16: s = 5'h18; 5'd17: s = 5'h16; 5'd18: s = 5'h0b; 5'd19: s = 5'h11;
         5'd20: s = 5'h03; 5'd21: s = 5'h05; 5'd22: s = 5'h1c; 5'd23: s = 5'h1f;
         5'd24: s = 5'h17; 5'd25: s = 5'h1b; 5'd26: s = 5'h04; 5'd27: s = 5'h08;
         5'd28: s = 5'h0f; 5'd29: s = 5'h0c; 5'd30: s = 5'h10; 5'd31: s = 5'h02;
         default: s = '0;
      endcase
      return s;
   endfunction

   state_t          r_state;
   state_t          w_state_nxt;
   logic [319:0]    r_work;
   logic [319:0]    w_work_nxt;
   logic [CW-1:0]   r_cnt;
   logic            r_mode;
   logic            r_done;
   logic            w_last;

   assign w_last = (r_cnt == CW'(N - 1));

   // Lane k holds x_k; x0 is the top 64 bits and the MSB of every column.
   always_comb begin
      logic [63:0] w_lane [5];
      logic [63:0] w_lane_out [5];
      logic [5:0]  w_idx;
      logic [4:0]  w_col;
      logic [4:0]  w_sub;
      w_lane[0] = r_work[319:256];
      w_lane[1] = r_work[255:192];
      w_lane[2] = r_work[191:128];
      w_lane[3] = r_work[127:64];
      w_lane[4] = r_work[63:0];
      w_lane_out = w_lane;
      w_idx = '0;
      w_col = '0;
      w_sub = '0;
      for (int i = 0; i < SBOX_PER_CYCLE; i++) begin
         w_idx = 6'(int'(r_cnt) * SBOX_PER_CYCLE + i);
         w_col = {w_lane[0][w_idx], w_lane[1][w_idx], w_lane[2][w_idx],
                  w_lane[3][w_idx], w_lane[4][w_idx]};
         w_sub = r_mode ? sbox_inv(w_col) : sbox_fwd(w_col);
         for (int k = 0; k < 5; k++) begin
            w_lane_out[k][w_idx] = w_sub[4-k];
         end
      end
      w_work_nxt = {w_lane_out[0], w_lane_out[1], w_lane_out[2],
                    w_lane_out[3], w_lane_out[4]};
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start_i) w_state_nxt = RUN;
         RUN:     if (w_last)  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // The counter stops at N-1 on the final edge; the next start clears it.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_work <= '0;
         r_cnt  <= '0;
         r_mode <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == IDLE) begin
            if (start_i) begin
               r_work <= state_i;
               r_mode <= inv_i;
               r_cnt  <= '0;
            end
         end else begin
            r_work <= w_work_nxt;
            if (w_last) r_done <= 1'b1;
            else        r_cnt  <= r_cnt + 1'b1;
         end
      end
   end

   assign substitution_o = r_work;
   assign busy_o         = (r_state == RUN);
   assign done_o         = r_done;

endmodule

// File: tb/tb_ps_iter.sv
// Directed and randomised checks of ps_iter against a bitsliced ASCON S-box model.
module tb_ps_iter;

   localparam logic [319:0] SPEC_V =
      320'h00001000808c0001_6cb10ad9ca912f80_691aed630e8190ef_0c4c36a20853217c_46487b3e06d9d7a8;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic         clk = 1'b0;
   logic         rst;
   logic         start_i, start_x, inv_i;
   logic [319:0] state_i;
   logic [319:0] sub8, sub1, sub64;
   logic         busy8, busy1, busy64;
   logic         done8, done1, done64;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ps_iter #(.SBOX_PER_CYCLE(8)) u_dut8 (
      .clock_i(clk), .reset_i(rst), .start_i(start_i), .inv_i(inv_i),
      .state_i(state_i), .substitution_o(sub8), .busy_o(busy8), .done_o(done8));

   ps_iter #(.SBOX_PER_CYCLE(1)) u_dut1 (
      .clock_i(clk), .reset_i(rst), .start_i(start_x), .inv_i(inv_i),
      .state_i(state_i), .substitution_o(sub1), .busy_o(busy1), .done_o(done1));

   ps_iter #(.SBOX_PER_CYCLE(64)) u_dut64 (
      .clock_i(clk), .reset_i(rst), .start_i(start_x), .inv_i(inv_i),
      .state_i(state_i), .substitution_o(sub64), .busy_o(busy64), .done_o(done64));

   // Bitsliced ASCON S-box on the five 64-bit lanes, x0 in the top bits.
   function automatic logic [319:0] fwd_model(input logic [319:0] s);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128]; x3 = s[127:64]; x4 = s[63:0];
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      return {x0, x1, x2, x3, x4};
   endfunction

   function automatic logic [319:0] rand320();
      logic [319:0] r;
      for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check320(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One operation on the SBOX_PER_CYCLE=8 instance; returns at the done cycle.
   task automatic run8(input string tag, input logic [319:0] s, input logic inv,
                       output logic [319:0] res);
      int lat;
      state_i = s; inv_i = inv; start_i = 1'b1;
      step();
      start_i = 1'b0;
      check_int({tag, "_busy"}, int'(busy8), 1);
      lat = 0;
      while (!done8 && lat < 200) begin
         step();
         lat++;
      end
      check_int({tag, "_lat"}, lat, 8);
      res = sub8;
   endtask

   initial begin
      logic [319:0] res, res2, x, y;
      int dcount, first, l1, l8, l64;
      logic [319:0] r1, r8, r64;
      logic inv;

      rst = 1'b1; start_i = 1'b0; start_x = 1'b0; inv_i = 1'b0; state_i = '0;
      repeat (3) step();
      check_int("rst_busy", int'(busy8), 0);
      check_int("rst_done", int'(done8), 0);
      check320("rst_sub", sub8, '0);

      // Reset has priority over a simultaneous start.
      start_i = 1'b1; state_i = {5{ONES}};
      step();
      start_i = 1'b0;
      check_int("rst_start_busy", int'(busy8), 0);
      check320("rst_start_sub", sub8, '0);
      rst = 1'b0;
      step();

      run8("zero_fwd", '0, 1'b0, res);
      check320("zero_fwd_res", res, {64'h0, 64'h0, ONES, 64'h0, 64'h0});
      step();
      check_int("done_one_cycle", int'(done8), 0);
      check320("idle_hold", sub8, {64'h0, 64'h0, ONES, 64'h0, 64'h0});

      run8("ones_fwd", {5{ONES}}, 1'b0, res);
      check320("ones_fwd_res", res, {ONES, 64'h0, ONES, ONES, ONES});
      run8("ones_inv", res, 1'b1, res2);
      check320("ones_inv_res", res2, {5{ONES}});

      run8("spec_fwd", SPEC_V, 1'b0, res);
      check320("spec_fwd_res", res, fwd_model(SPEC_V));
      run8("spec_inv", res, 1'b1, res2);
      check320("spec_inv_res", res2, SPEC_V);
      step();

      // Inputs changing and a start pulse mid-run must be ignored.
      state_i = SPEC_V; inv_i = 1'b0; start_i = 1'b1;
      step();
      start_i = 1'b0;
      dcount = 0; first = -1; res = '0;
      for (int k = 1; k <= 20; k++) begin
         if (k == 3) begin
            state_i = rand320(); inv_i = 1'b1; start_i = 1'b1;
         end
         if (k == 4) start_i = 1'b0;
         step();
         if (done8) begin
            dcount++;
            if (first < 0) begin
               first = k;
               res = sub8;
            end
         end
      end
      check_int("busy_prot_lat", first, 8);
      check_int("busy_prot_pulses", dcount, 1);
      check320("busy_prot_res", res, fwd_model(SPEC_V));

      // Start during the done cycle is accepted without a bubble.
      x = rand320();
      run8("b2b_a", x, 1'b0, res);
      check320("b2b_a_res", res, fwd_model(x));
      y = rand320();
      run8("b2b_b", y, 1'b0, res);
      check320("b2b_b_res", res, fwd_model(y));
      step();

      // Reset in the middle of a run aborts it with no done pulse.
      state_i = SPEC_V; inv_i = 1'b0; start_i = 1'b1;
      step();
      start_i = 1'b0;
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_int("midrst_busy", int'(busy8), 0);
      check_int("midrst_done", int'(done8), 0);
      check320("midrst_sub", sub8, '0);
      dcount = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (done8) dcount++;
      end
      check_int("midrst_no_done", dcount, 0);

      // Latency for 1, 8 and 64 S-boxes per cycle, forward then inverse.
      for (int pass = 0; pass < 2; pass++) begin
         inv = (pass == 1);
         state_i = inv ? fwd_model(SPEC_V) : SPEC_V;
         inv_i = inv; start_i = 1'b1; start_x = 1'b1;
         step();
         start_i = 1'b0; start_x = 1'b0;
         l1 = -1; l8 = -1; l64 = -1; r1 = '0; r8 = '0; r64 = '0;
         for (int k = 1; k <= 80; k++) begin
            step();
            if (done1 && l1 < 0)   begin l1 = k;  r1 = sub1;  end
            if (done8 && l8 < 0)   begin l8 = k;  r8 = sub8;  end
            if (done64 && l64 < 0) begin l64 = k; r64 = sub64; end
         end
         check_int("lat_p1", l1, 64);
         check_int("lat_p8", l8, 8);
         check_int("lat_p64", l64, 1);
         check320("res_p1", r1, inv ? SPEC_V : fwd_model(SPEC_V));
         check320("res_p8", r8, inv ? SPEC_V : fwd_model(SPEC_V));
         check320("res_p64", r64, inv ? SPEC_V : fwd_model(SPEC_V));
      end

      for (int n = 0; n < 1000; n++) begin
         x = rand320();
         inv = 1'($urandom_range(1, 0));
         if (inv) begin
            run8("rnd_inv", fwd_model(x), 1'b1, res);
            check320("rnd_inv_res", res, x);
         end else begin
            run8("rnd_fwd", x, 1'b0, res);
            check320("rnd_fwd_res", res, fwd_model(x));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
